// File: rtl/output_buffer_write_arbiter_pkg.sv
// Shared types for the output-buffer write arbiter.
// State encodings are fixed so they can be matched against other tools and probes.
package output_buffer_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/output_buffer_write_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request bit found scanning from ptr upward,
// wrapping modulo N_REQ. Purely combinational.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] pos;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N_REQ)) begin
        pos = pos - (IDX_W + 1)'(N_REQ);
      end
      if (req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/output_buffer_write_arbiter.sv
// Grants the single output-buffer write port to one of N_REQ PE write controllers,
// round-robin, holding the grant while the buffer is full.
module output_buffer_write_arbiter
  import output_buffer_write_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        write_req,
  input  logic [N_REQ-1:0]        write_in_buffer,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    buf_full,
  output logic [N_REQ-1:0]        ready,
  output logic                    buf_wr_en,
  output logic [DATA_W-1:0]       buf_wr_data,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [CNT_W-1:0]        wr_count,
  output logic                    proto_err
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             strobe;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (write_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign strobe = write_in_buffer[grant_idx];

  always_comb begin
    state_next  = state;
    ready       = '0;
    buf_wr_en   = 1'b0;
    buf_wr_data = '0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (!buf_full) begin
          ready[grant_idx] = 1'b1;
          state_next       = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
        // A reset landing on the write cycle discards the word rather than committing it.
        buf_wr_en  = strobe && !rst;
        if (buf_wr_en) buf_wr_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      if (state == ST_IDLE && pick_valid) grant_idx <= pick_idx;
      if (state == ST_WRITE) begin
        rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        if (strobe) wr_count  <= wr_count + CNT_W'(1);
        else        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_buffer_write_arbiter.sv
// Directed bench for the output-buffer write arbiter with a data scoreboard.
module tb_output_buffer_write_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        write_req = '0;
  logic [N_REQ-1:0]        write_in_buffer = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic                    buf_full = 1'b0;
  logic [N_REQ-1:0]        ready;
  logic                    buf_wr_en;
  logic [DATA_W-1:0]       buf_wr_data;
  logic                    busy;
  logic [IDX_W-1:0]        grant_idx;
  logic [CNT_W-1:0]        wr_count;
  logic                    proto_err;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_ready_cyc = -1;
  int          seq = 0;
  int          exp_count = 0;
  bit          exp_proto = 1'b0;
  logic [31:0] sb_q[$];

  output_buffer_write_arbiter #(
    .N_REQ (N_REQ), .DATA_W (DATA_W), .IDX_W (IDX_W), .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .write_req       (write_req),
    .write_in_buffer (write_in_buffer),
    .req_data        (req_data),
    .buf_full        (buf_full),
    .ready           (ready),
    .buf_wr_en       (buf_wr_en),
    .buf_wr_data     (buf_wr_data),
    .busy            (busy),
    .grant_idx       (grant_idx),
    .wr_count        (wr_count),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full grant: IDLE cycle, optional full stall, GRANT, WRITE, then back in IDLE.
  task automatic xact(input logic [3:0] req, input int exp_idx, input bit give_strobe,
                      input int full_cyc, input bit drop, input bit chk_gap);
    logic [3:0]  onehot;
    logic [31:0] word;
    onehot          = 4'(1 << exp_idx);
    write_req       = req;
    buf_full        = 1'b0;
    write_in_buffer = '0;
    @(negedge clk);
    check("idle_ready", ready, 0);
    check("idle_busy", busy, 0);
    step();
    for (int k = 0; k < full_cyc; k++) begin
      buf_full = 1'b1;
      @(negedge clk);
      check("stall_ready", ready, 0);
      check("stall_busy", busy, 1);
      step();
    end
    buf_full = 1'b0;
    @(negedge clk);
    check("grant_ready", ready, onehot);
    check("grant_idx", grant_idx, exp_idx);
    check("grant_busy", busy, 1);
    if (chk_gap) check("grant_gap", cyc - last_ready_cyc, 3);
    last_ready_cyc = cyc;
    step();
    if (drop) write_req = write_req & ~onehot;
    for (int i = 0; i < N_REQ; i++)
      req_data[i*DATA_W +: DATA_W] = {16'hCAFE, 8'(seq), 8'(i)};
    word = {16'hCAFE, 8'(seq), 8'(exp_idx)};
    seq++;
    // Non-granted strobes are always driven high to show they are ignored.
    write_in_buffer = give_strobe ? 4'hF : ~onehot;
    if (give_strobe) begin
      sb_q.push_back(word);
      exp_count++;
    end else begin
      exp_proto = 1'b1;
    end
    @(negedge clk);
    check("write_ready", ready, 0);
    check("write_en", buf_wr_en, give_strobe);
    if (buf_wr_en) begin
      if (sb_q.size() == 0) check("sb_empty", 1, 0);
      else check("write_data", buf_wr_data, sb_q.pop_front());
    end else begin
      check("write_data_zero", buf_wr_data, 0);
    end
    step();
    write_in_buffer = '0;
    check("wr_count", wr_count, exp_count);
    check("proto_err", proto_err, exp_proto);
    check("back_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_wr_en"}, buf_wr_en, 0);
    check({tag, "_wr_data"}, buf_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_idx"}, grant_idx, 0);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // T1: single requester 2; T3: rr_ptr now 3, requests 1001 -> 3 then 0
    xact(4'b0100, 2, 1'b1, 0, 1'b1, 1'b0);
    xact(4'b1001, 3, 1'b1, 0, 1'b1, 1'b0);
    xact(4'b0001, 0, 1'b1, 0, 1'b1, 1'b0);

    // T2: all four request continuously from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 0;
    check_reset_outputs("reset2");
    xact(4'hF, 0, 1'b1, 0, 1'b0, 1'b0);
    xact(4'hF, 1, 1'b1, 0, 1'b0, 1'b1);
    xact(4'hF, 2, 1'b1, 0, 1'b0, 1'b1);
    xact(4'hF, 3, 1'b1, 0, 1'b0, 1'b1);
    xact(4'hF, 0, 1'b1, 0, 1'b0, 1'b1);

    // T4: buffer full for 5 cycles after entering GRANT (rr_ptr=1 -> requester 3)
    xact(4'b1000, 3, 1'b1, 5, 1'b1, 1'b0);

    // T5: missing strobe sets sticky proto_err; next grant keeps it set
    xact(4'b0110, 1, 1'b0, 0, 1'b1, 1'b0);
    xact(4'b0100, 2, 1'b1, 0, 1'b1, 1'b0);

    // T6: reset asserted during WRITE drops the write
    write_req = 4'b0001;
    step();
    @(negedge clk);
    check("t6_grant", ready, 4'b0001);
    step();
    write_req       = '0;
    write_in_buffer = 4'b0001;
    rst             = 1'b1;
    @(negedge clk);
    check("t6_wr_en_dropped", buf_wr_en, 0);
    step();
    rst             = 1'b0;
    write_in_buffer = '0;
    exp_count       = 0;
    exp_proto       = 1'b0;
    check_reset_outputs("t6");

    // After reset rr_ptr is 0 again
    xact(4'hF, 0, 1'b1, 0, 1'b1, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
